// File: rtl/repsig_stream_arbiter.sv
// Two-input, segment-granular stream arbiter. It holds a grant for a whole fiber segment and merges the two done tokens into one.
// Define REPSIG_ARB_CNT_EN to add the per-input segment counters seg_cnt0 and seg_cnt1.
module repsig_stream_arbiter #(
    parameter int DATA_WIDTH = 17,
    parameter int LVL_WIDTH  = 16
`ifdef REPSIG_ARB_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  tile_en,
    input  logic [LVL_WIDTH-1:0]  stop_lvl,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef REPSIG_ARB_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  seg_cnt0,
    output logic [CNT_WIDTH-1:0]  seg_cnt1
`endif
);

    localparam logic [DATA_WIDTH-1:0] DONE_TOK = 17'h10100;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_PASS      = 2'd1,
        ST_EMIT_DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic       gnt_r;
    logic       prio_r;
    logic [1:0] done_seen_r;

    logic                  en_s;
    logic [1:0]            valid_s;
    logic [1:0]            done_s;
    logic [1:0]            end_s;
    logic [1:0]            absorb_s;
    logic [1:0]            cand_s;
    logic                  winner_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;
    logic                  gnt_valid_s;
    logic                  gnt_done_s;
    logic                  gnt_end_s;
    logic                  gnt_rdy_s;
    logic                  xfer_s;
    logic                  seg_close_s;

    function automatic logic is_done(input logic [DATA_WIDTH-1:0] d);
        return d == DONE_TOK;
    endfunction

    // Stop token whose zero-extended level reaches the threshold.
    function automatic logic is_seg_end(input logic ctl, input logic [1:0] kind,
                                        input logic [7:0] lvl8, input logic [LVL_WIDTH-1:0] thr);
        return ctl && (kind == 2'b00) && ({{(LVL_WIDTH-8){1'b0}}, lvl8} >= thr);
    endfunction

    // Token decode and grant-path selection.
    always_comb begin
        en_s        = clk_en & tile_en;
        valid_s     = {in1_valid, in0_valid};
        done_s      = {is_done(in1_data), is_done(in0_data)};
        end_s       = {is_seg_end(in1_data[16], in1_data[9:8], in1_data[7:0], stop_lvl),
                       is_seg_end(in0_data[16], in0_data[9:8], in0_data[7:0], stop_lvl)};
        absorb_s    = {2{en_s}} & valid_s & done_s & ~done_seen_r;
        cand_s      = valid_s & ~done_s & ~done_seen_r;
        winner_s    = cand_s[prio_r] ? prio_r : ~prio_r;
        gnt_data_s  = gnt_r ? in1_data : in0_data;
        gnt_valid_s = valid_s[gnt_r];
        gnt_done_s  = done_s[gnt_r];
        gnt_end_s   = end_s[gnt_r];
        xfer_s      = (state_r == ST_PASS) && en_s && gnt_valid_s && !gnt_done_s && out_ready;
        seg_close_s = xfer_s && gnt_end_s;
    end

    // Handshake outputs; PASS is a zero-latency pass-through of the granted input.
    always_comb begin
        out_data  = {DATA_WIDTH{1'b0}};
        out_valid = 1'b0;
        gnt_rdy_s = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (state_r)
            ST_ARB: begin
                in0_ready = absorb_s[0];
                in1_ready = absorb_s[1];
            end
            ST_PASS: begin
                out_data = gnt_data_s;
                if (en_s && gnt_valid_s) begin
                    // A done token on the granted input is swallowed, never forwarded.
                    out_valid = !gnt_done_s;
                    gnt_rdy_s = gnt_done_s | out_ready;
                end else begin
                    gnt_rdy_s = 1'b0;
                end
                in0_ready = gnt_rdy_s & ~gnt_r;
                in1_ready = gnt_rdy_s & gnt_r;
            end
            ST_EMIT_DONE: begin
                out_data  = DONE_TOK;
                out_valid = en_s;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Arbitration state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ARB;
            gnt_r       <= 1'b0;
            prio_r      <= 1'b0;
            done_seen_r <= 2'b00;
        end else if (clk_en && flush) begin
            state_r     <= ST_ARB;
            gnt_r       <= 1'b0;
            prio_r      <= 1'b0;
            done_seen_r <= 2'b00;
        end else if (en_s) begin
            case (state_r)
                ST_ARB: begin
                    done_seen_r <= done_seen_r | absorb_s;
                    if (done_seen_r == 2'b11) begin
                        state_r <= ST_EMIT_DONE;
                    end else if (cand_s != 2'b00) begin
                        gnt_r   <= winner_s;
                        state_r <= ST_PASS;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_PASS: begin
                    if (gnt_valid_s && gnt_done_s) begin
                        done_seen_r[gnt_r] <= 1'b1;
                        prio_r             <= ~gnt_r;
                        state_r            <= ST_ARB;
                    end else if (seg_close_s) begin
                        prio_r  <= ~gnt_r;
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_PASS;
                    end
                end
                ST_EMIT_DONE: begin
                    if (out_ready) begin
                        done_seen_r <= 2'b00;
                        prio_r      <= 1'b0;
                        state_r     <= ST_ARB;
                    end else begin
                        state_r <= ST_EMIT_DONE;
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

`ifdef REPSIG_ARB_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Saturating count of segment-end tokens forwarded from each input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_cnt0 <= {CNT_WIDTH{1'b0}};
            seg_cnt1 <= {CNT_WIDTH{1'b0}};
        end else if (clk_en && flush) begin
            seg_cnt0 <= {CNT_WIDTH{1'b0}};
            seg_cnt1 <= {CNT_WIDTH{1'b0}};
        end else begin
            if (seg_close_s && !gnt_r && (seg_cnt0 != CNT_MAX)) seg_cnt0 <= seg_cnt0 + CNT_ONE;
            if (seg_close_s && gnt_r && (seg_cnt1 != CNT_MAX))  seg_cnt1 <= seg_cnt1 + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_repsig_stream_arbiter.sv
// Randomized scoreboard bench for repsig_stream_arbiter against a segment-level reference model.
module tb_repsig_stream_arbiter;
    localparam logic [16:0] DONE_TOK = 17'h10100;

    logic        clk = 1'b0;
    logic        rst, clk_en, flush, tile_en;
    logic [15:0] stop_lvl;
    logic [16:0] in0_data, in1_data, out_data;
    logic        in0_valid, in1_valid, in0_ready, in1_ready;
    logic        out_valid, out_ready;
`ifdef REPSIG_ARB_CNT_EN
    logic [15:0] seg_cnt0, seg_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    logic [16:0] src0_q[$], src1_q[$], mq0[$], mq1[$], exp_q[$];
    bit  mon_en = 1'b0;
    int  model_cnt0 = 0;
    int  model_cnt1 = 0;

    repsig_stream_arbiter dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .stop_lvl(stop_lvl),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef REPSIG_ARB_CNT_EN
        , .seg_cnt0(seg_cnt0), .seg_cnt1(seg_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit tok_done(input logic [16:0] t);
        return t == DONE_TOK;
    endfunction

    function automatic bit tok_end(input logic [16:0] t, input logic [15:0] lvl);
        return t[16] && (t[9:8] == 2'b00) && (16'(t[7:0]) >= lvl);
    endfunction

    // Non-terminating token: plain coordinate, low-level stop, or other control.
    function automatic logic [16:0] rand_body(input logic [15:0] lvl);
        int k;
        k = $urandom_range(0, 2);
        if (k == 0 || lvl == 16'd0) return {1'b0, 16'($urandom)};
        else if (k == 1) return {1'b1, 6'($urandom), 2'b00, 8'($urandom_range(0, 32'(lvl) - 1))};
        else return {1'b1, 6'($urandom), 1'b1, 1'($urandom), 8'($urandom)};
    endfunction

    function automatic logic [16:0] rand_end(input logic [15:0] lvl);
        logic [7:0] e8;
        e8 = (lvl > 16'd253) ? 8'($urandom) : 8'(32'(lvl) + $urandom_range(0, 2));
        return {1'b1, 6'($urandom), 2'b00, e8};
    endfunction

    task automatic push_tok(input int which, input logic [16:0] t);
        if (which == 0) begin src0_q.push_back(t); mq0.push_back(t); end
        else begin src1_q.push_back(t); mq1.push_back(t); end
    endtask

    task automatic gen_round(input int ntiles, input logic [15:0] lvl);
        for (int t = 0; t < ntiles; t++) begin
            for (int i = 0; i < 2; i++) begin
                int nseg;
                nseg = $urandom_range(0, 3);
                for (int s = 0; s < nseg; s++) begin
                    int len;
                    len = $urandom_range(0, 2);
                    for (int b = 0; b < len; b++) push_tok(i, rand_body(lvl));
                    push_tok(i, rand_end(lvl));
                end
                if ($urandom_range(0, 3) == 0) begin
                    for (int b = 0; b < 1 + $urandom_range(0, 1); b++) push_tok(i, rand_body(lvl));
                end
                push_tok(i, DONE_TOK);
            end
        end
    endtask

    // Whole-segment reference: round-robin over segments, dones merged per tile.
    task automatic run_model(input logic [15:0] lvl);
        bit p;
        bit [1:0] ds;
        bit c0, c1, w;
        logic [16:0] t;
        p = 1'b0;
        ds = 2'b00;
        forever begin
            if (ds == 2'b11) begin
                exp_q.push_back(DONE_TOK);
                ds = 2'b00;
                p = 1'b0;
            end
            if (mq0.size() == 0 && mq1.size() == 0) break;
            if (!ds[0] && mq0.size() > 0 && tok_done(mq0[0])) begin void'(mq0.pop_front()); ds[0] = 1'b1; end
            if (!ds[1] && mq1.size() > 0 && tok_done(mq1[0])) begin void'(mq1.pop_front()); ds[1] = 1'b1; end
            c0 = !ds[0] && mq0.size() > 0 && !tok_done(mq0[0]);
            c1 = !ds[1] && mq1.size() > 0 && !tok_done(mq1[0]);
            if (!c0 && !c1) begin
                if (ds == 2'b11) continue;
                break;
            end
            w = (p == 1'b0) ? !c0 : c1;
            forever begin
                t = (w == 1'b0) ? mq0.pop_front() : mq1.pop_front();
                if (tok_done(t)) begin ds[w] = 1'b1; break; end
                exp_q.push_back(t);
                if (tok_end(t, lvl)) begin
                    if (w == 1'b0) model_cnt0++; else model_cnt1++;
                    break;
                end
            end
            p = ~w;
        end
    endtask

    // Output monitor: scoreboard pop on every transfer, plus stall stability.
    bit          stall_prev = 1'b0;
    logic [16:0] data_prev = 17'd0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_prev && out_valid) chk("stall_hold", 32'(out_data), 32'(data_prev));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'h1ffff);
                    else chk("out_token", 32'(out_data), 32'(exp_q.pop_front()));
                end
                stall_prev = out_valid && !out_ready;
                data_prev  = out_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        bit f0, f1;
        int cyc;
        rst = 1'b1; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1; stop_lvl = 16'd0;
        in0_data = DONE_TOK; in0_valid = 1'b1; in1_data = 17'd5; in1_valid = 1'b1; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in0_ready_done_head", 32'(in0_ready), 32'd1);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // tile_en low: every handshake output forced low and state held.
        tile_en = 1'b0; in1_data = 17'd7;
        @(negedge clk);
        chk("tile_off_in0_ready", 32'(in0_ready), 32'd0);
        chk("tile_off_in1_ready", 32'(in1_ready), 32'd0);
        chk("tile_off_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in0_valid = 1'b0; in1_valid = 1'b0; tile_en = 1'b1;
        @(posedge clk);
        #1;

        mon_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            stop_lvl = (r == 2) ? 16'hffff : 16'($urandom_range(0, 3));
            gen_round(4, stop_lvl);
            run_model(stop_lvl);
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 5000) begin
                in0_valid = src0_q.size() > 0;
                in0_data  = (src0_q.size() > 0) ? src0_q[0] : 17'd0;
                in1_valid = src1_q.size() > 0;
                in1_data  = (src1_q.size() > 0) ? src1_q[0] : 17'd0;
                out_ready = $urandom_range(0, 3) != 0;
                clk_en    = $urandom_range(0, 9) != 0;
                @(negedge clk);
                f0 = in0_valid && in0_ready;
                f1 = in1_valid && in1_ready;
                @(posedge clk);
                #1;
                if (f0 && src0_q.size() > 0) void'(src0_q.pop_front());
                if (f1 && src1_q.size() > 0) void'(src1_q.pop_front());
                cyc++;
            end
            chk("round_drain_exp", 32'(exp_q.size()), 32'd0);
            chk("round_drain_src0", 32'(src0_q.size()), 32'd0);
            chk("round_drain_src1", 32'(src1_q.size()), 32'd0);
            exp_q.delete(); src0_q.delete(); src1_q.delete();
            in0_valid = 1'b0; in1_valid = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
`ifdef REPSIG_ARB_CNT_EN
        chk("seg_cnt0", 32'(seg_cnt0), 32'(model_cnt0));
        chk("seg_cnt1", 32'(seg_cnt1), 32'(model_cnt1));
`endif
        mon_en = 1'b0;

        // Flush in PASS drops the grant.
        stop_lvl = 16'd0; out_ready = 1'b0; in0_data = 17'd5; in0_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("pass_out_valid", 32'(out_valid), 32'd1);
        chk("pass_out_data", 32'(out_data), 32'd5);
        chk("pass_stalled_ready", 32'(in0_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);

        // Flush also clears done_seen: a second done is absorbed again.
        in0_data = DONE_TOK;
        #1;
        chk("absorb_ready", 32'(in0_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("done_seen_blocks", 32'(in0_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_clears_done_seen", 32'(in0_ready), 32'd1);
`ifdef REPSIG_ARB_CNT_EN
        chk("flush_seg_cnt0", 32'(seg_cnt0), 32'd0);
        chk("flush_seg_cnt1", 32'(seg_cnt1), 32'd0);
`endif
        in0_valid = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/repsig_stream_arbiter.md
# repsig_stream_arbiter

Two-input, segment-granular stream arbiter that lets two upstream sparse coordinate streams share one downstream consumer, typically a repeat-signal generator. It accepts 17-bit sparse tokens: bit 16 marks a control token, stop tokens carry a level, and the done token is 17'h10100. A grant is held for a whole fiber segment, ending at a qualifying stop token, so segments are never interleaved. The two done tokens are merged into a single downstream done.

## Interface
- DATA_WIDTH, 17, token width; bit 16 is the control flag. Only 17 is supported.
- LVL_WIDTH, 16, width of `stop_lvl`.
- CNT_WIDTH, 16, width of the segment counters (only with `REPSIG_ARB_CNT_EN`).

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  clock enable. When 0: state holds, all `*_ready`=0, `out_valid`=0.
- flush  in  1  synchronous flush, qualified by `clk_en`.
- tile_en  in  1  tile enable. When 0: same output behaviour as `clk_en`=0, and state is held.
- stop_lvl  in  LVL_WIDTH  minimum stop level that ends a segment.
- in0_data / in1_data  in  DATA_WIDTH  upstream tokens.
- in0_valid / in1_valid  in  1  upstream valid.
- in0_ready / in1_ready  out  1  upstream ready.
- out_data  out  DATA_WIDTH  merged token stream.
- out_valid  out  1  downstream valid.
- out_ready  in  1  downstream ready.
- seg_cnt0 / seg_cnt1  out  CNT_WIDTH  segments forwarded per input (only with `REPSIG_ARB_CNT_EN`).

## Operation
- Token decode:
  - done = `data == 17'h10100`.
  - stop = `data[16]` and `data[9:8] == 2'b00`; its level is `data[7:0]`, zero-extended.
  - segment end = stop token with level ≥ `stop_lvl`.
- State registers: `state` ∈ {ARB, PASS, EMIT_DONE}, `gnt` (1 bit), `prio` (1 bit), `done_seen[1:0]`.
- ARB:
  - An input i with `in_i_valid`, a done token at its head, and `!done_seen[i]` gets `in_i_ready`=1. The token is absorbed, not forwarded, and `done_seen[i]` is set. Both inputs may be absorbed in the same cycle.
  - An input with a non-done head and `!done_seen[i]` is a candidate.
  - If there are candidates, the winner is the one matching `prio` if it is a candidate, otherwise the other. `gnt` := winner and state goes to PASS. No data transfers in that cycle.
  - If `done_seen == 2'b11`, state goes to EMIT_DONE (this check has priority over granting).
  - `out_valid`=0 and `out_data`=0 in ARB.
- PASS is a combinational pass-through of input `gnt`:
  - `out_data` = `in_gnt_data`, `out_valid` = `in_gnt_valid`, `in_gnt_ready` = `out_ready`. The other input's ready is 0.
  - On transfer of a segment-end token: state goes to ARB and `prio` := `~gnt`.
  - If the granted input presents a done token: it is not forwarded, `in_gnt_ready`=1, `done_seen[gnt]` is set, state goes to ARB, and `prio` := `~gnt`.
- EMIT_DONE:
  - `out_valid`=1 and `out_data`=17'h10100.
  - On `out_ready`: `done_seen` := 0, `prio` := 0, state goes to ARB.
  - Both `in*_ready` are 0.
- An input with `done_seen` set is ignored until the merged done has been sent, so next-tile data waits.

## Timing
- Reset and flush set: state=ARB, `gnt`=0, `prio`=0, `done_seen`=0, and counters=0.
- Output values at reset: `out_valid`=0, `out_data`=0, both readies 0 unless a done token is at an input head.
- Flush mid-segment drops the grant. Tokens already transferred are not replayed.
- Latency:
  - 1 bubble cycle per segment (ARB), then 0-cycle data latency with a combinational valid/ready path.
  - Merged done: 1 cycle in ARB after the second done is absorbed, then EMIT_DONE.
- Handshake: valid/ready; a transfer happens when both are high with `clk_en` & `tile_en`. `out_data` is stable while `out_valid` && !`out_ready`, because upstream holds its data.
- Simultaneous candidates: `prio` decides, and it toggles after every completed segment, giving strict round-robin.
- `stop_lvl` larger than any token level: segments end only at done tokens.

## Configuration
- `REPSIG_ARB_CNT_EN`:
  - Defined: `seg_cnt0` and `seg_cnt1` exist. Each increments when a segment-end token from that input transfers, saturates at all-ones, and clears on reset or flush.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- `stop_lvl`=0; in0: 5, 6, 17'h10000; in1: 9, 17'h10000 → out: 5, 6, 10000, bubble, 9, 10000; `seg_cnt0`=1 and `seg_cnt1`=1.
- Both inputs continuously valid with three segments each → grants alternate 0, 1, 0, 1, 0, 1, with one ARB cycle between segments.
- `stop_lvl`=1; in0: 4, 17'h10000, 7, 17'h10001 → all four forwarded in one grant; in1 is not granted until 10001 transfers.
- in0 sends done first; in1 sends 3, 17'h10000, done → out: 3, 10000, then a single 17'h10100; in0's next token is held (`in0_ready`=0) until after the done.
- `out_ready` low for 3 cycles mid-segment → `out_data` is held, `in_gnt_ready`=0, and there is no loss or duplication.
- `flush` (or async `rst`) asserted in PASS → next cycle state=ARB, `out_valid`=0, `done_seen`=0; `tile_en`=0 forces all readies and valids to 0.
